// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write channel (AW/W/B) among three
// burst-granular FIFO requesters; one full burst per grant.
module axi_wr_arbiter #(
    parameter int BURST_LEN  = 16,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,
    input  logic [2:0]              req,
    input  logic [3*ADDR_WIDTH-1:0] req_addr,
    input  logic [3*DATA_WIDTH-1:0] rd_data,
    output logic [2:0]              rd_en,
    output logic [2:0]              grant,
    output logic [2:0]              done,
    output logic                    err,
    output logic [ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY
);

    localparam int SIZE_LOG2  = $clog2(DATA_WIDTH / 8);
    localparam int ALIGN_BITS = $clog2(BURST_LEN * DATA_WIDTH / 8);
    localparam int CNT_W      = $clog2(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [1:0]              gidx_q, gidx_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [CNT_W-1:0]        beat_q, beat_d;

    logic                    pick_valid;
    logic [1:0]              pick_idx;
    logic [1:0]              cand0, cand1, cand2;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    logic [2:0]              grant_oh;
    logic                    w_hs;
    logic                    b_hs;

    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Search order starts at the pointer and wraps modulo 3.
    assign cand0 = ptr_q;
    assign cand1 = wrap_inc(cand0);
    assign cand2 = wrap_inc(cand1);

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pick_valid = 1'b1;
        pick_idx   = cand0;
        if (req[cand0])      pick_idx = cand0;
        else if (req[cand1]) pick_idx = cand1;
        else if (req[cand2]) pick_idx = cand2;
        else                 pick_valid = 1'b0;
    end

    always_comb begin
        pick_addr = req_addr[0 +: ADDR_WIDTH];
        case (pick_idx)
            2'd1:    pick_addr = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
            2'd2:    pick_addr = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
            default: pick_addr = req_addr[0 +: ADDR_WIDTH];
        endcase
    end

    always_comb begin
        M_AXI_WDATA = rd_data[0 +: DATA_WIDTH];
        case (gidx_q)
            2'd1:    M_AXI_WDATA = rd_data[DATA_WIDTH +: DATA_WIDTH];
            2'd2:    M_AXI_WDATA = rd_data[2*DATA_WIDTH +: DATA_WIDTH];
            default: M_AXI_WDATA = rd_data[0 +: DATA_WIDTH];
        endcase
    end

    assign grant_oh = (state_q != ST_IDLE) ? (3'b001 << gidx_q) : 3'b000;
    assign w_hs     = (state_q == ST_W) && M_AXI_WREADY;
    assign b_hs     = (state_q == ST_B) && M_AXI_BVALID;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        awaddr_d = awaddr_q;
        beat_d   = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gidx_d   = pick_idx;
                    awaddr_d = pick_addr & ADDR_MASK;
                    ptr_d    = wrap_inc(pick_idx);
                    beat_d   = '0;
                    state_d  = ST_AW;
                end
            end
            ST_AW: begin
                if (M_AXI_AWREADY) state_d = ST_W;
            end
            ST_W: begin
                if (w_hs) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (beat_q == LAST_BEAT) state_d = ST_B;
                end
            end
            ST_B: begin
                if (M_AXI_BVALID) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd0;
            gidx_q   <= 2'd0;
            awaddr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            awaddr_q <= awaddr_d;
            beat_q   <= beat_d;
        end
    end

    assign grant         = grant_oh;
    assign rd_en         = w_hs ? grant_oh : 3'b000;
    assign done          = b_hs ? grant_oh : 3'b000;
    assign err           = b_hs && (M_AXI_BRESP != 2'b00);

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'(SIZE_LOG2);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = (state_q == ST_AW);
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (state_q == ST_W);
    assign M_AXI_WLAST   = (state_q == ST_W) && (beat_q == LAST_BEAT);
    assign M_AXI_BREADY  = (state_q == ST_B);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: table-driven bursts, a reset-abort
// sequence, then randomized bursts against a transaction-level model.
module tb_axi_wr_arbiter;

    localparam int BL = 16;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam logic [31:0] ALIGN_MASK = ~(32'(BL * DW / 8) - 32'd1);

    logic            aclk;
    logic            aresetn;
    logic [2:0]      req;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] rd_data;
    logic [2:0]      rd_en;
    logic [2:0]      grant;
    logic [2:0]      done;
    logic            err;
    logic [0:0]      awid;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;
    logic [31:0] salt;

    axi_wr_arbiter #(
        .BURST_LEN(BL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(1)
    ) dut (
        .M_AXI_ACLK(aclk),       .M_AXI_ARESETN(aresetn),
        .req(req),               .req_addr(req_addr),
        .rd_data(rd_data),       .rd_en(rd_en),
        .grant(grant),           .done(done),
        .err(err),
        .M_AXI_AWID(awid),       .M_AXI_AWADDR(awaddr),
        .M_AXI_AWLEN(awlen),     .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata),     .M_AXI_WSTRB(wstrb),
        .M_AXI_WLAST(wlast),     .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp),     .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  rq;
        logic [31:0] base;
        int          idx;
        logic [31:0] addr;
        int          aw_delay;
        int          wmode;
        int          b_delay;
        logic [1:0]  bresp;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Round-robin rule: first requester at or after the pointer, modulo 3.
    function automatic int model_pick(input logic [2:0] rq, input int ptr);
        for (int k = 0; k < 3; k++) begin
            if (rq[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] word(input int g, input int beat);
        return {salt, 32'(g), 32'(beat), ~salt};
    endfunction

    task automatic drive_data(input int g, input int beat);
        for (int i = 0; i < 3; i++) begin
            if (i == g) rd_data[i*DW +: DW] = word(i, beat);
            else        rd_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic set_addrs(input logic [31:0] base);
        for (int i = 0; i < 3; i++) req_addr[i*AW +: AW] = base + 32'(i) * 32'h1000;
    endtask

    task automatic idle_cycle();
        req = 3'b000;
        #2;
        check("idle_grant", grant, 3'b000);
        check("idle_awvalid", awvalid, 1'b0);
        check("idle_done", done, 3'b000);
        @(negedge aclk);
    endtask

    // Entered at a falling edge with the arbiter in IDLE; leaves it in IDLE.
    task automatic do_burst(input logic [2:0] rq, input logic [31:0] base, input int exp_idx,
                            input logic [31:0] exp_addr, input int aw_delay, input int wmode,
                            input int b_delay, input logic [1:0] b_code);
        logic [2:0] oh;
        int beat, cyc, pops, lasts;
        logic wr;
        oh   = 3'b001 << exp_idx;
        salt = $urandom;
        req  = rq;
        set_addrs(base);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        drive_data(exp_idx, 0);
        #2;
        check("arb_grant_idle", grant, 3'b000);
        check("arb_awvalid_idle", awvalid, 1'b0);
        check("arb_done_idle", done, 3'b000);
        @(negedge aclk);

        for (int d = 0; d <= aw_delay; d++) begin
            req     = 3'($urandom);
            awready = (d == aw_delay);
            #2;
            check("aw_valid", awvalid, 1'b1);
            check("aw_addr", awaddr, exp_addr);
            check("aw_grant", grant, oh);
            check("aw_wvalid", wvalid, 1'b0);
            check("aw_rd_en", rd_en, 3'b000);
            @(negedge aclk);
        end
        awready = 1'b0;

        beat = 0; cyc = 0; pops = 0; lasts = 0;
        while (beat < BL) begin
            case (wmode)
                0:       wr = 1'b1;
                1:       wr = (cyc % 2 == 0);
                default: wr = (cyc > 64) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            wready = wr;
            drive_data(exp_idx, beat);
            #2;
            check("w_valid", wvalid, 1'b1);
            check("w_awvalid", awvalid, 1'b0);
            check("w_data", wdata, word(exp_idx, beat));
            check("w_last", wlast, (beat == BL - 1));
            check("w_rd_en", rd_en, wr ? oh : 3'b000);
            check("w_grant", grant, oh);
            check("w_done", done, 3'b000);
            if (rd_en != 3'b000) pops++;
            if (wlast && wr) lasts++;
            if (wr) beat++;
            cyc++;
            @(negedge aclk);
        end
        wready = 1'b0;
        check("w_pop_count", pops, BL);
        check("w_last_count", lasts, 1);

        for (int d = 0; d <= b_delay; d++) begin
            bvalid = (d == b_delay);
            bresp  = bvalid ? b_code : 2'($urandom);
            #2;
            check("b_wvalid", wvalid, 1'b0);
            check("b_ready", bready, 1'b1);
            check("b_grant", grant, oh);
            check("b_done", done, bvalid ? oh : 3'b000);
            check("b_err", err, bvalid && (b_code != 2'b00));
            @(negedge aclk);
        end
        bvalid = 1'b0;
        req    = 3'b000;
        m_ptr  = (exp_idx + 1) % 3;
    endtask

    initial begin
        tbl[0]  = '{3'b111, 32'h1000_0000, 0, 32'h1000_0000, 0, 0, 0, 2'b00};
        tbl[1]  = '{3'b111, 32'h1000_0010, 1, 32'h1000_1000, 0, 0, 0, 2'b00};
        tbl[2]  = '{3'b111, 32'h2000_0FFF, 2, 32'h2000_2F00, 0, 0, 0, 2'b00};
        tbl[3]  = '{3'b111, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 0, 2'b00};
        tbl[4]  = '{3'b111, 32'hFFFF_E0AB, 1, 32'hFFFF_F000, 0, 0, 0, 2'b00};
        tbl[5]  = '{3'b111, 32'h0000_0100, 2, 32'h0000_2100, 0, 0, 0, 2'b00};
        tbl[6]  = '{3'b010, 32'h0000_0234, 1, 32'h0000_1200, 0, 0, 0, 2'b00};
        tbl[7]  = '{3'b010, 32'h0ABC_0000, 1, 32'h0ABC_1000, 0, 0, 0, 2'b00};
        tbl[8]  = '{3'b100, 32'h0000_5555, 2, 32'h0000_7500, 5, 1, 0, 2'b00};
        tbl[9]  = '{3'b001, 32'h0300_00FF, 0, 32'h0300_0000, 0, 0, 0, 2'b10};
        tbl[10] = '{3'b101, 32'h0000_0000, 2, 32'h0000_2000, 1, 2, 3, 2'b00};
        tbl[11] = '{3'b011, 32'h0000_0040, 0, 32'h0000_0000, 2, 1, 1, 2'b11};

        aresetn = 1'b0;
        req = 3'b000; req_addr = '0; rd_data = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        salt = 32'd0;
        @(negedge aclk);
        #2;
        check("rst_grant", grant, 3'b000);
        check("rst_done", done, 3'b000);
        check("rst_err", err, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("const_awid", awid, 1'b0);
        check("const_awlen", awlen, 8'd15);
        check("const_awsize", awsize, 3'd4);
        check("const_awburst", awburst, 2'b01);
        check("const_wstrb", wstrb, {(DW/8){1'b1}});
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_burst(tbl[i].rq, tbl[i].base, tbl[i].idx, tbl[i].addr,
                     tbl[i].aw_delay, tbl[i].wmode, tbl[i].b_delay, tbl[i].bresp);
        end

        // Reset in the middle of W beat 7: burst abandoned, no done, pointer back to 0.
        salt = $urandom;
        req  = 3'b001;
        set_addrs(32'h1234_5678);
        drive_data(0, 0);
        #2;
        check("abort_idle_grant", grant, 3'b000);
        @(negedge aclk);
        awready = 1'b1;
        #2;
        check("abort_aw_valid", awvalid, 1'b1);
        check("abort_aw_grant", grant, 3'b001);
        @(negedge aclk);
        awready = 1'b0;
        for (int b = 0; b < 7; b++) begin
            wready = 1'b1;
            drive_data(0, b);
            #2;
            check("abort_w_rd_en", rd_en, 3'b001);
            @(negedge aclk);
        end
        wready = 1'b1;
        drive_data(0, 7);
        #2;
        check("abort_pre_wvalid", wvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        check("abort_wvalid", wvalid, 1'b0);
        check("abort_grant", grant, 3'b000);
        check("abort_rd_en", rd_en, 3'b000);
        check("abort_done", done, 3'b000);
        check("abort_bready", bready, 1'b0);
        @(negedge aclk);
        check("abort_hold_done", done, 3'b000);
        check("abort_hold_awaddr", awaddr, 32'h0);
        wready  = 1'b0;
        req     = 3'b000;
        aresetn = 1'b1;
        m_ptr   = 0;

        do_burst(3'b101, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 0, 2'b00);
        do_burst(3'b100, 32'h1111_1111, 2, 32'h1111_3100, 0, 0, 0, 2'b00);

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  rq;
            logic [31:0] base;
            int          idx;
            if ($urandom_range(0, 4) == 0) idle_cycle();
            rq   = 3'($urandom_range(1, 7));
            base = $urandom;
            idx  = model_pick(rq, m_ptr);
            do_burst(rq, base, idx, (base + 32'(idx) * 32'h1000) & ALIGN_MASK,
                     $urandom_range(0, 3), 2, $urandom_range(0, 3), 2'($urandom));
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
